// File: rtl/cond_diff_subtractor_pipe_pkg.sv
// Shared constants for the conditional-difference subtractor pipeline.
//   DEFAULT_WIDTH : default operand width of the top module
//   half_width()  : width of each half-chain for a given operand width
package cond_diff_subtractor_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int half_width(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/cond_diff_subtractor_pipe_full_subtractor.sv
// One-bit full subtractor built from gate-level expressions.
// Ports:
//   a_i, b_i  : operand bits (computes a_i - b_i - bin_i)
//   bin_i     : borrow in
//   d_o       : difference bit
//   bout_o    : borrow out
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic axb;

    assign axb    = a_i ^ b_i;
    assign d_o    = axb ^ bin_i;
    // Borrow when b exceeds a, or when the bits match and a borrow is pending.
    assign bout_o = (~a_i & b_i) | (~axb & bin_i);

endmodule

// File: rtl/cond_diff_subtractor_pipe.sv
// Two-stage pipelined conditional-difference subtractor: diff = a - b - bin.
// Stage 1 subtracts the low half directly and precomputes the high half for
// both possible borrow-ins; stage 2 picks the high half with the low borrow.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : input handshake for a, b, bin
//   a, b, bin            : minuend, subtrahend, borrow in
//   out_valid / out_ready: output handshake
//   diff                 : (a - b - bin) mod 2^WIDTH
//   bout                 : unsigned borrow out (a < b + bin)
//   ovf                  : signed overflow
//   zero                 : diff == 0
// WIDTH must be even and at least 4.
module cond_diff_subtractor_pipe
    import cond_diff_subtractor_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int HALF = half_width(WIDTH);

    // ---------------- ripple chains ----------------
    logic [HALF:0]   lo_bw, h0_bw, h1_bw;
    logic [HALF-1:0] lo_d, h0_d, h1_d;

    assign lo_bw[0] = bin;
    assign h0_bw[0] = 1'b0;
    assign h1_bw[0] = 1'b1;

    for (genvar i = 0; i < HALF; i++) begin : g_chain
        full_subtractor u_lo (
            .a_i(a[i]), .b_i(b[i]), .bin_i(lo_bw[i]),
            .d_o(lo_d[i]), .bout_o(lo_bw[i+1])
        );
        full_subtractor u_hi0 (
            .a_i(a[HALF+i]), .b_i(b[HALF+i]), .bin_i(h0_bw[i]),
            .d_o(h0_d[i]), .bout_o(h0_bw[i+1])
        );
        full_subtractor u_hi1 (
            .a_i(a[HALF+i]), .b_i(b[HALF+i]), .bin_i(h1_bw[i]),
            .d_o(h1_d[i]), .bout_o(h1_bw[i+1])
        );
    end

    // ---------------- pipeline control ----------------
    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv, in_xfer;

    assign s2_adv   = !s2_valid_q | out_ready;
    assign s1_adv   = !s1_valid_q | s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid & s1_adv;

    // ---------------- stage 1 ----------------
    logic [HALF-1:0] lo_diff_q, hi_d0_q, hi_d1_q;
    logic            lo_borrow_q, hi_b0_q, hi_b1_q, a_msb_q, b_msb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            lo_diff_q   <= '0;
            lo_borrow_q <= 1'b0;
            hi_d0_q     <= '0;
            hi_b0_q     <= 1'b0;
            hi_d1_q     <= '0;
            hi_b1_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid_q  <= 1'b1;
                lo_diff_q   <= lo_d;
                lo_borrow_q <= lo_bw[HALF];
                hi_d0_q     <= h0_d;
                hi_b0_q     <= h0_bw[HALF];
                hi_d1_q     <= h1_d;
                hi_b1_q     <= h1_bw[HALF];
                a_msb_q     <= a[WIDTH-1];
                b_msb_q     <= b[WIDTH-1];
            end else if (s2_adv) begin
                s1_valid_q  <= 1'b0;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [WIDTH-1:0] diff_d, diff_q;
    logic             bout_d, bout_q, ovf_d, ovf_q, zero_d, zero_q;

    always_comb begin
        diff_d = {(lo_borrow_q ? hi_d1_q : hi_d0_q), lo_diff_q};
        bout_d = lo_borrow_q ? hi_b1_q : hi_b0_q;
        zero_d = (diff_d == '0);
        ovf_d  = (a_msb_q != b_msb_q) & (diff_d[WIDTH-1] != a_msb_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            // Result registers hold when a bubble passes through.
            if (s1_valid_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cond_diff_subtractor_pipe.sv
module tb_cond_diff_subtractor_pipe;

    localparam int W  = 8;
    localparam int NV = 11;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    cond_diff_subtractor_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t tbl [NV];
    vec_t exp_q [$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        vec_t r;
        logic [W:0] t;
        t      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        r.a    = ma;
        r.b    = mb;
        r.bin  = mbin;
        r.diff = t[W-1:0];
        r.bout = t[W];
        r.ovf  = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
        r.zero = (t[W-1:0] == '0);
        return r;
    endfunction

    task automatic run_table();
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            a         = tbl[i].a;
            b         = tbl[i].b;
            bin       = tbl[i].bin;
            out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d early_valid", i), {31'b0, out_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("tbl%0d diff", i), {24'b0, diff}, {24'b0, tbl[i].diff});
            chk($sformatf("tbl%0d bout", i), {31'b0, bout}, {31'b0, tbl[i].bout});
            chk($sformatf("tbl%0d ovf", i), {31'b0, ovf}, {31'b0, tbl[i].ovf});
            chk($sformatf("tbl%0d zero", i), {31'b0, zero}, {31'b0, tbl[i].zero});
        end
    endtask

    // Streams n items through the pipe; rnd selects random valid/ready,
    // otherwise back-to-back input with out_ready low for cycles 3..5.
    task automatic run_stream(input int n, input bit rnd, input string tag);
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        int limit;
        bit pend = 1'b0;
        bit stall_prev = 1'b0;
        logic [W-1:0] s_diff;
        logic s_bout, s_ovf, s_zero;
        logic exp_rdy;
        vec_t e;
        limit = n * 20 + 50;
        exp_q.delete();
        while (rcvd < n && cyc < limit) begin
            @(posedge clk); #1;
            if (!pend && sent < n) begin
                if (!rnd || $urandom_range(0, 3) != 0) begin
                    pend = 1'b1;
                    if (rnd) begin
                        a   = W'($urandom);
                        b   = W'($urandom);
                        bin = 1'($urandom);
                    end else begin
                        a   = tbl[sent % NV].a;
                        b   = tbl[sent % NV].b;
                        bin = tbl[sent % NV].bin;
                    end
                end
            end
            in_valid  = pend;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc < 6);
            @(negedge clk);
            exp_rdy = !((sent - rcvd) == 2 && !out_ready);
            chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, exp_rdy});
            if (stall_prev) begin
                chk({tag, " stall_valid"}, {31'b0, out_valid}, 32'd1);
                chk({tag, " stall_diff"}, {24'b0, diff}, {24'b0, s_diff});
                chk({tag, " stall_flags"}, {29'b0, bout, ovf, zero}, {29'b0, s_bout, s_ovf, s_zero});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " spurious_valid"}, {31'b0, out_valid}, 32'd0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk({tag, " diff"}, {24'b0, diff}, {24'b0, e.diff});
                    chk({tag, " flags"}, {29'b0, bout, ovf, zero}, {29'b0, e.bout, e.ovf, e.zero});
                    rcvd++;
                end
            end
            stall_prev = out_valid && !out_ready;
            s_diff = diff; s_bout = bout; s_ovf = ovf; s_zero = zero;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
                sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, " items_received"}, rcvd, n);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{8'h08, 8'h08, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst diff", {24'b0, diff}, 32'd0);
        chk("rst flags", {29'b0, bout, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_table();
        run_stream(6, 1'b0, "bp");

        // Reset with two items in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h11; b = 8'h01; bin = 1'b0;
        @(posedge clk); #1;
        a = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid full out_valid", {31'b0, out_valid}, 32'd1);
        chk("mid full in_ready", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid rst diff", {24'b0, diff}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post rst no stale", {31'b0, out_valid}, 32'd0);
        end

        run_stream(10000, 1'b1, "rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
